// File: rtl/game_state_ctrl_pkg.sv
// game_state_ctrl_pkg: shared game state encodings, default parameters and score arithmetic.
package game_state_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE           = 2'b00,
    OPENING_SCREEN = 2'b01,
    GAME_RUNNING   = 2'b10,
    GAME_OVER      = 2'b11
  } game_state_e;
  localparam int unsigned DEF_START_LIVES  = 3;
  localparam int unsigned DEF_INTRO_TICKS  = 120;
  localparam int unsigned DEF_INVULN_TICKS = 60;
  localparam int unsigned DEF_EXIT_BONUS   = 100;
  localparam int unsigned DEF_MAX_LEVEL    = 15;
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/game_state_ctrl_btn_sync_edge.sv
// btn_sync_edge: 2-flop synchroniser with rising-edge detect per bit.
module btn_sync_edge #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o
);
  logic [W-1:0] s1_q, s2_q, prev_q;
  logic [1:0]   vld_q;
  // prev stays high until the synchroniser has filled, so a button held through reset never edges
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '1;
      vld_q  <= '0;
    end else begin
      s1_q  <= d_i;
      s2_q  <= s1_q;
      vld_q <= {vld_q[0], 1'b1};
      if (vld_q[1]) prev_q <= s2_q;
    end
  end
  assign rise_o = s2_q & ~prev_q;
endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: game flow FSM with lives, level, score and post-hit immunity.
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int unsigned START_LIVES  = DEF_START_LIVES,
  parameter int unsigned INTRO_TICKS  = DEF_INTRO_TICKS,
  parameter int unsigned INVULN_TICKS = DEF_INVULN_TICKS,
  parameter int unsigned EXIT_BONUS   = DEF_EXIT_BONUS,
  parameter int unsigned MAX_LEVEL    = DEF_MAX_LEVEL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_tick,
  input  logic [4:0]  btn,
  input  logic        collision_detected,
  input  logic        exit_reached,
  output logic [1:0]  game_state,
  output logic        round_start,
  output logic [1:0]  lives,
  output logic [3:0]  level,
  output logic [15:0] score,
  output logic        invuln
);
  game_state_e state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic [3:0]  level_q, level_d;
  logic [15:0] score_q, score_d, score_t;
  logic [15:0] intro_q, intro_d, inv_q, inv_d;
  logic        rs_q, start_evt;
  logic [3:0]  unused_rise;
  btn_sync_edge #(.W(5)) u_btn (
    .clk    (clk),
    .rst    (rst),
    .d_i    (btn),
    .rise_o ({unused_rise, start_evt})
  );
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    score_d = score_q;
    intro_d = intro_q;
    inv_d   = (game_tick && inv_q != '0) ? inv_q - 16'd1 : inv_q;
    score_t = game_tick ? sat_add16(score_q, 16'd1) : score_q;
    case (state_q)
      IDLE, GAME_OVER: if (start_evt) begin
        state_d = OPENING_SCREEN;
        lives_d = 2'(START_LIVES);
        level_d = 4'd1;
        score_d = '0;
        intro_d = '0;
      end
      OPENING_SCREEN: begin
        intro_d = game_tick ? intro_q + 16'd1 : intro_q;
        if (start_evt || (game_tick && intro_q == 16'(INTRO_TICKS - 1))) state_d = GAME_RUNNING;
      end
      GAME_RUNNING: begin
        score_d = score_t;
        // exit takes priority over a same-cycle hit; the tick increment lands before the bonus
        if (exit_reached) begin
          state_d = OPENING_SCREEN;
          level_d = (level_q >= 4'(MAX_LEVEL)) ? level_q : level_q + 4'd1;
          score_d = sat_add16(score_t, 16'(EXIT_BONUS));
          inv_d   = '0;
          intro_d = '0;
        end else if (collision_detected && inv_q == '0) begin
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) state_d = GAME_OVER;
          else inv_d = 16'(INVULN_TICKS);
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lives_q <= 2'(START_LIVES);
      level_q <= 4'd1;
      score_q <= '0;
      intro_q <= '0;
      inv_q   <= '0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      score_q <= score_d;
      intro_q <= intro_d;
      inv_q   <= inv_d;
      rs_q    <= state_d == GAME_RUNNING && state_q != GAME_RUNNING;
    end
  end
  assign game_state  = state_q;
  assign round_start = rs_q;
  assign lives       = lives_q;
  assign level       = level_q;
  assign score       = score_q;
  assign invuln      = inv_q != '0;
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed scenarios plus random stimulus against a behavioural game model.
module tb_game_state_ctrl;
  logic        clk = 1'b0, rst = 1'b1, game_tick = 1'b0, collision_detected = 1'b0, exit_reached = 1'b0;
  logic [4:0]  btn = '0;
  logic [1:0]  game_state, lives;
  logic        round_start, invuln;
  logic [3:0]  level;
  logic [15:0] score;
  int n_chk = 0, n_fail = 0;
  int m_state, m_lives, m_level, m_score, m_inv, m_intro;
  bit m_rs, m_live = 1'b0;
  int bq[$];

  game_state_ctrl dut (
    .clk(clk), .rst(rst), .game_tick(game_tick), .btn(btn),
    .collision_detected(collision_detected), .exit_reached(exit_reached),
    .game_state(game_state), .round_start(round_start), .lives(lives),
    .level(level), .score(score), .invuln(invuln)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return v > 65535 ? 65535 : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the start press is seen two edges after btn[0] goes high, given it was low the edge before
  // and both samples were taken after reset released.
  always @(posedge clk) begin
    bit start;
    int prev, inv0;
    m_live = 1'b1;
    if (rst) begin
      m_state = 0; m_lives = 3; m_level = 1; m_score = 0; m_inv = 0; m_intro = 0; m_rs = 1'b0;
      bq.delete();
    end else begin
      bq.push_back(int'(btn[0]));
      if (bq.size() > 4) void'(bq.pop_front());
      start = bq.size() == 4 && bq[1] == 1 && bq[0] == 0;
      prev = m_state;
      inv0 = m_inv;
      if (m_state == 0 || m_state == 3) begin
        if (start) begin
          m_state = 1; m_lives = 3; m_level = 1; m_score = 0; m_intro = 0;
        end
      end else if (m_state == 1) begin
        if (game_tick) m_intro++;
        if (start || m_intro == 120) m_state = 2;
      end else begin
        if (game_tick) begin
          m_score = sat(m_score + 1);
          if (m_inv > 0) m_inv--;
        end
        if (exit_reached) begin
          m_state = 1; m_level = m_level < 15 ? m_level + 1 : 15;
          m_score = sat(m_score + 100); m_inv = 0; m_intro = 0;
        end else if (collision_detected && inv0 == 0) begin
          m_lives--;
          if (m_lives == 0) m_state = 3;
          else m_inv = 60;
        end
      end
      m_rs = m_state == 2 && prev != 2;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("game_state", int'(game_state), m_state);
      chk("round_start", int'(round_start), int'(m_rs));
      chk("lives", int'(lives), m_lives);
      chk("level", int'(level), m_level);
      chk("score", int'(score), m_score);
      chk("invuln", int'(invuln), int'(m_inv != 0));
    end
  end

  task automatic drive(input bit t, input bit c, input bit e, input bit b0);
    game_tick = t;
    collision_detected = c;
    exit_reached = e;
    btn = {4'($urandom()), b0};
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n, input bit c);
    repeat (n) drive(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic press();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_state", int'(game_state), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_level", int'(level), 1);
    chk("rst_score", int'(score), 0);
    chk("rst_invuln", int'(invuln), 0);
    idle(4);
    press();
    chk("s1_opening", int'(game_state), 1);
    ticks(119, 1'b0);
    chk("s1_still_opening", int'(game_state), 1);
    ticks(1, 1'b0);
    chk("s1_running", int'(game_state), 2);
    chk("s1_round_start", int'(round_start), 1);
    idle(1);
    chk("s1_round_start_once", int'(round_start), 0);
    ticks(5, 1'b1);
    chk("s2_lives2", int'(lives), 2);
    ticks(55, 1'b0);
    chk("s2_invuln_tick59", int'(invuln), 1);
    ticks(1, 1'b0);
    chk("s2_invuln_tick60", int'(invuln), 0);
    ticks(1, 1'b1);
    chk("s2_lives1", int'(lives), 1);
    ticks(60, 1'b0);
    ticks(1, 1'b1);
    chk("s3_over", int'(game_state), 3);
    chk("s3_lives0", int'(lives), 0);
    chk("s3_score", int'(score), 123);
    ticks(10, 1'b0);
    chk("s3_score_frozen", int'(score), 123);
    press();
    chk("s4_reopen", int'(game_state), 1);
    chk("s4_lives", int'(lives), 3);
    chk("s4_score0", int'(score), 0);
    press();
    chk("s4_running", int'(game_state), 2);
    ticks(500, 1'b0);
    chk("s4_score500", int'(score), 500);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("s4_state", int'(game_state), 1);
    chk("s4_level", int'(level), 2);
    chk("s4_score601", int'(score), 601);
    chk("s4_lives_kept", int'(lives), 3);
    press();
    ticks(20, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("s6_pre_lives", int'(lives), 2);
    rst = 1'b1;
    repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    repeat (10) drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("s6_state", int'(game_state), 0);
    chk("s6_lives", int'(lives), 3);
    chk("s6_level", int'(level), 1);
    chk("s6_score", int'(score), 0);
    chk("s6_invuln", int'(invuln), 0);
    idle(3);
    press();
    chk("s6_repress", int'(game_state), 1);
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 599) == 0;
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0);
    end
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(4);
    press();
    press();
    chk("s5_running", int'(game_state), 2);
    repeat (700) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      press();
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("s5_state", int'(game_state), 1);
    chk("s5_score_sat", int'(score), 65535);
    chk("s5_level_sat", int'(level), 15);
    press();
    ticks(3, 1'b0);
    chk("s5_tick_sat", int'(score), 65535);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
